// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register file and its storage cells.
package cpu_pkg;

    localparam int CPU_DW   = 32;
    localparam int CPU_NREG = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_cell_en.sv
// One DW-bit register with asynchronous active-low clear and a synchronous load enable.
module reg_cell_en #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_q;

    // Ternary instead of if() so an X enable corrupts the cell rather than silently holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= i_en ? i_d : r_q;
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_32x32_onehot.sv
// 32x32 register file written by a one-hot select, with two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero r0, and a multi-hot select flag.
module regfile_32x32_onehot
    import cpu_pkg::*;
#(
    parameter int DW      = CPU_DW,
    parameter int NREG    = CPU_NREG,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREG-1:0] WSel,
    input  logic [DW-1:0]   WD,
    input  reg_addr_t       RA1,
    input  reg_addr_t       RA2,
    output logic [DW-1:0]   RD1,
    output logic [DW-1:0]   RD2,
    output logic            WErr
);

    localparam logic [NREG-1:0] ONE = NREG'(1);

    logic [DW-1:0] w_q [NREG];
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_rd2;
    logic          w_multi;
    logic          r_werr;

    genvar k;
    generate
        for (k = 0; k < NREG; k++) begin : g_reg
            if (ZERO_R0 && (k == int'(REG_ZERO))) begin : g_zero
                assign w_q[k] = '0;
            end else begin : g_cell
                reg_cell_en #(.DW(DW)) u_cell (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .i_en  (WSel[k]),
                    .i_d   (WD),
                    .o_q   (w_q[k])
                );
            end
        end
    endgenerate

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign w_multi = |(WSel & (WSel - ONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_werr <= 1'b0;
        else        r_werr <= w_multi;
    end

    assign WErr = r_werr;

    // Zero-register rule outranks bypass; ternaries keep X selects visible in simulation.
    assign w_rd1 = (ZERO_R0 && (RA1 == REG_ZERO)) ? '0 :
                   (BYPASS && WSel[RA1])         ? WD : w_q[RA1];
    assign w_rd2 = (ZERO_R0 && (RA2 == REG_ZERO)) ? '0 :
                   (BYPASS && WSel[RA2])         ? WD : w_q[RA2];

    assign RD1 = rst_n ? w_rd1 : '0;
    assign RD2 = rst_n ? w_rd2 : '0;

endmodule

// File: doc/regfile_32x32_onehot.md
Name: regfile_32x32_onehot

Overview:
- 32-entry x 32-bit general-purpose register file for the simple CPU.
- Consumes the one-hot write-select vector produced by the 5-to-32 write-address decoder.
- Provides two asynchronous read ports, addressed by 5-bit fields, for the operand-fetch stage.
- Register 0 is hardwired to zero; an optional write-to-read bypass hides same-cycle write-back hazards.

Parameters:
- DW, 32, data width of each register.
- NREG, 32, number of registers; fixed by the width of the one-hot select.
- BYPASS, 1, 1 = read ports return the write data when reading a register being written this cycle; 0 = read returns the stored value.
- ZERO_R0, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register.

Ports:
- clk  input  1  system clock; registers update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- WSel  input  NREG  one-hot write select from the decoder (decoder En already folded in).
- WD  input  DW  write data.
- RA1  input  5  read address, port 1.
- RA2  input  5  read address, port 2.
- RD1  output  DW  read data, port 1 (combinational).
- RD2  output  DW  read data, port 2 (combinational).
- WErr  output  1  registered flag: last sampled WSel had more than one bit set.

Behaviour:
- Reset:
  - rst_n low clears all registers to 0 and WErr to 0 immediately, independent of clk.
  - Holding rst_n low forces RD1 and RD2 to 0 regardless of BYPASS.
  - Reset deassertion is taken synchronously by the integrator; the block adds no synchroniser.
- Write:
  - On each rising clk edge with rst_n high, every register k with WSel[k]=1 loads WD.
  - Registers with WSel[k]=0 hold their value.
  - Write latency is 1 cycle: the value becomes visible from the stored array on the cycle after the edge.
- WSel all zero: no write (the decoder was disabled); the array is unchanged.
- WSel with more than one bit set:
  - All selected registers are written; no priority is applied.
  - WErr is set to 1 on that edge and stays 1 until the next edge whose WSel has at most one bit set.
  - The illegal case is flagged, not masked, so verification can catch decoder faults.
- Register 0 with ZERO_R0=1:
  - Storage for register 0 is removed or tied to 0; WSel[0] is ignored for writing.
  - WSel[0] still counts toward the WErr popcount.
  - RA=0 returns 0 even when BYPASS=1 and WSel[0]=1.
- Read:
  - RDn = reg[RAn], purely combinational, zero-cycle latency.
  - Both ports may address the same register at once.
- Bypass (BYPASS=1):
  - If WSel[RAn]=1 in the current cycle, RDn = WD instead of the stored value.
  - The ZERO_R0 rule takes precedence over bypass.
- Reset mid-write: an asynchronous reset coinciding with a clk edge wins; all registers end at 0 and no write takes effect.
- No X propagation:
  - An out-of-range address cannot occur (5 bits and 32 entries).
  - An X on WSel bits must not be silently treated as 0 in simulation; the bench checks for X.

Decomposition:
- Shared package cpu_pkg:
  - DW and NREG constants.
  - REG_ZERO index constant (0).
  - The 5-bit register-address typedef.
- One sub-module, reg_cell_en: DW-bit register with async active-low clear and a synchronous load enable; instantiated NREG times (NREG-1 times when ZERO_R0=1).
- Read muxes, bypass and WErr popcount logic live in the top level.

Test Plan:
- Reset: load several registers, pulse rst_n low mid-cycle -> all RD read 0 immediately; after release, reading r1..r31 returns 0 and WErr=0.
- Single write/readback: WSel=32'h0000_0020, WD=32'hDEADBEEF, edge; then RA1=5 -> RD1=32'hDEADBEEF; RA2=6 -> RD2=0.
- Register 0: WSel=32'h0000_0001, WD=32'hFFFF_FFFF, edge; RA1=0 -> RD1=0, including during the write cycle with BYPASS=1.
- Bypass: r7=32'h1111_1111 stored; in the same cycle WSel=32'h80, WD=32'h2222_2222, RA1=RA2=7 -> RD1=RD2=32'h2222_2222 before the edge (BYPASS=1); with BYPASS=0 both read 32'h1111_1111 before the edge and 32'h2222_2222 after it.
- Multi-hot: WSel=32'h0000_0006, WD=32'hA5A5_A5A5, edge -> r1=r2=32'hA5A5_A5A5 and WErr=1; next edge with WSel=0 -> WErr=0 and the array is unchanged.
- Random sweep: 2000 cycles of random one-hot or zero WSel, WD, RA1 and RA2 against a reference model -> zero mismatches and WErr never set.
